// File: rtl/adder_result_checker.sv
// adder_result_checker
// Scoreboard for a pipelined adder. While running, it computes a + b + cin at
// full WIDTH+1 bits for every valid operand set. It delays that expected value
// by LATENCY cycles, compares it against the adder's {cout,s} output, and
// keeps pass/fail statistics.
//
// Optional feature macro: ADDER_CHK_HALT_ON_ERROR_EN
//   defined   -> the first mismatch parks the FSM in FAIL until start or rst
//   undefined -> checking carries on after mismatches (FAIL never entered)
//
// Ports
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous active-high reset
//   start       in   1        pulse: clear all state and enter RUN
//   stop        in   1        pulse: stop sampling, drain in-flight checks
//   in_valid    in   1        a/b/cin valid this cycle
//   a, b        in   WIDTH    operands given to the adder
//   cin         in   1        carry-in given to the adder
//   dut_result  in   WIDTH+1  adder output {cout,s}
//   busy        out  1        high in RUN or DRAIN
//   err         out  1        sticky mismatch flag
//   err_count   out  16       saturating mismatch count
//   chk_count   out  32       saturating completed-comparison count
//   fail_exp    out  WIDTH+1  expected value of the first mismatch
//   fail_got    out  WIDTH+1  observed value of the first mismatch

module adder_result_checker #(
  parameter int WIDTH   = 128,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH:0]   dut_result,
  output logic             busy,
  output logic             err,
  output logic [15:0]      err_count,
  output logic [31:0]      chk_count,
  output logic [WIDTH:0]   fail_exp,
  output logic [WIDTH:0]   fail_got
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [LATENCY-1:0] r_dlValid;
  logic [WIDTH:0]     r_dlExp [LATENCY];
  logic               r_err;
  logic [15:0]        r_errCount;
  logic [31:0]        r_chkCount;
  logic [WIDTH:0]     r_failExp;
  logic [WIDTH:0]     r_failGot;

  logic [WIDTH:0]     w_sum;
  logic               w_push;
  logic               w_compare;
  logic               w_mismatch;
  logic               w_lineEmpty;

  // Zero-extend both operands so the carry-out lands in the top bit.
  assign w_sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign w_push      = (r_state == S_RUN) && in_valid;
  assign w_lineEmpty = (r_dlValid == '0);

  // The tail of the delay line was pushed LATENCY edges ago. A start on this
  // edge discards it, and a halted checker (FAIL) stops scoring entirely.
  assign w_compare  = r_dlValid[LATENCY-1] && (r_state != S_FAIL) && !start;
  assign w_mismatch = w_compare && (r_dlExp[LATENCY-1] != dut_result);

  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign err       = r_err;
  assign err_count = r_errCount;
  assign chk_count = r_chkCount;
  assign fail_exp  = r_failExp;
  assign fail_got  = r_failGot;

  // Next-state logic. start overrides everything, including a stop on the
  // same cycle. DRAIN waits until no valid entry remains in the line.
  always_comb begin
    w_nextState = r_state;
    if (start) begin
      w_nextState = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
`ifdef ADDER_CHK_HALT_ON_ERROR_EN
          if (w_mismatch)   w_nextState = S_FAIL;
          else if (stop)    w_nextState = S_DRAIN;
`else
          if (stop)         w_nextState = S_DRAIN;
`endif
        end
        S_DRAIN: begin
`ifdef ADDER_CHK_HALT_ON_ERROR_EN
          if (w_mismatch)       w_nextState = S_FAIL;
          else if (w_lineEmpty) w_nextState = S_IDLE;
`else
          if (w_lineEmpty)      w_nextState = S_IDLE;
`endif
        end
        S_FAIL:  w_nextState = S_FAIL;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Delay line of expected sums. Bubbles are pushed whenever the checker is
  // not sampling. A start empties the line on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dlValid <= '0;
      for (int i = 0; i < LATENCY; i++) r_dlExp[i] <= '0;
    end else begin
      for (int i = LATENCY-1; i > 0; i--) begin
        r_dlValid[i] <= start ? 1'b0 : r_dlValid[i-1];
        r_dlExp[i]   <= r_dlExp[i-1];
      end
      r_dlValid[0] <= w_push && !start;
      r_dlExp[0]   <= w_sum;
    end
  end

  // Statistics. Both counters saturate. Only the first mismatch after start
  // is captured in fail_exp/fail_got.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_errCount <= '0;
      r_chkCount <= '0;
      r_failExp  <= '0;
      r_failGot  <= '0;
    end else if (start) begin
      r_err      <= 1'b0;
      r_errCount <= '0;
      r_chkCount <= '0;
      r_failExp  <= '0;
      r_failGot  <= '0;
    end else begin
      if (w_compare && (r_chkCount != '1)) r_chkCount <= r_chkCount + 32'd1;
      if (w_mismatch) begin
        if (r_errCount != '1) r_errCount <= r_errCount + 16'd1;
        if (!r_err) begin
          r_err     <= 1'b1;
          r_failExp <= r_dlExp[LATENCY-1];
          r_failGot <= dut_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker
// Directed bench for adder_result_checker (WIDTH=128, LATENCY=4). It contains
// a stand-in pipelined adder with per-item result corruption, and a
// transaction-level reference model built on a queue of timed expectations.
// A compare process checks every output against that model on each falling
// edge. Literal expectations pin the model in each directed scenario.
// Honours ADDER_CHK_HALT_ON_ERROR_EN where the expected values differ.

module tb_adder_result_checker;

  localparam int WIDTH = 128;
  localparam int LAT   = 4;
`ifdef ADDER_CHK_HALT_ON_ERROR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             in_valid = 1'b0;
  logic             cin = 1'b0;
  logic             corrupt = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH:0]   dut_result;
  logic             busy;
  logic             err;
  logic [15:0]      err_count;
  logic [31:0]      chk_count;
  logic [WIDTH:0]   fail_exp;
  logic [WIDTH:0]   fail_got;

  int checks = 0;
  int fails  = 0;
  bit checking = 1'b0;

  adder_result_checker #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .dut_result(dut_result),
    .busy(busy), .err(err), .err_count(err_count), .chk_count(chk_count),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clk = ~clk;

  // Stand-in adder under check: a LAT-stage pipe of the true sum. When
  // corrupt is set, the LSB of that item's result is flipped.
  logic [WIDTH:0] adderPipe [LAT];
  initial for (int i = 0; i < LAT; i++) adderPipe[i] = '0;
  always @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) adderPipe[i] <= adderPipe[i-1];
    adderPipe[0] <= ({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin}) ^ {{WIDTH{1'b0}}, corrupt};
  end
  assign dut_result = adderPipe[LAT-1];

  // Reference model: a queue of (due edge, expected sum) transactions.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_FAIL} mstate_t;
  typedef struct {
    int             due;
    logic [WIDTH:0] exp;
  } pend_t;

  pend_t          pend[$];
  pend_t          pe;
  int             cyc = 0;
  bit             wasEmpty;
  bit             mism;
  mstate_t        mState = M_IDLE;
  logic           mErr = 1'b0;
  logic [15:0]    mErrCnt = '0;
  logic [31:0]    mChkCnt = '0;
  logic [WIDTH:0] mFailExp = '0;
  logic [WIDTH:0] mFailGot = '0;
  logic [WIDTH:0] mSum;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend.delete();
      mState = M_IDLE;
      mErr = 1'b0; mErrCnt = '0; mChkCnt = '0; mFailExp = '0; mFailGot = '0;
    end else begin
      cyc++;
      wasEmpty = (pend.size() == 0);
      mism = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        pe = pend.pop_front();
        if (!start && mState != M_FAIL) begin
          if (mChkCnt != 32'hFFFF_FFFF) mChkCnt++;
          if (pe.exp != dut_result) begin
            mism = 1'b1;
            if (mErrCnt != 16'hFFFF) mErrCnt++;
            if (!mErr) begin
              mErr = 1'b1; mFailExp = pe.exp; mFailGot = dut_result;
            end
          end
        end
      end
      if (start) begin
        pend.delete();
        mErr = 1'b0; mErrCnt = '0; mChkCnt = '0; mFailExp = '0; mFailGot = '0;
        mState = M_RUN;
      end else begin
        if (mState == M_RUN && in_valid) begin
          mSum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
          pend.push_back('{due: cyc + LAT, exp: mSum});
        end
        if (HALT && mism && (mState == M_RUN || mState == M_DRAIN)) mState = M_FAIL;
        else if (mState == M_RUN && stop) mState = M_DRAIN;
        else if (mState == M_DRAIN && wasEmpty) mState = M_IDLE;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Every output is compared against the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_busy", busy, (mState == M_RUN || mState == M_DRAIN));
      checkOutput("model_err", err, mErr);
      checkOutput("model_err_count", err_count, mErrCnt);
      checkOutput("model_chk_count", chk_count, mChkCnt);
      checkOutput("model_fail_exp", fail_exp, mFailExp);
      checkOutput("model_fail_got", fail_got, mFailGot);
    end
  end

  task automatic applyStimulus(input logic st, input logic sp, input logic iv,
                               input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                               input logic ci, input logic cor);
    start = st; stop = sp; in_valid = iv; a = aa; b = bb; cin = ci; corrupt = cor;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [WIDTH:0] allOnes;
  logic [WIDTH:0] allOnesM1;
  int edges;

  initial begin
    allOnes   = '1;
    allOnesM1 = allOnes - 1;

    // Reset state
    #2 rst = 1'b1;
    checking = 1'b1;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_chk_count", chk_count, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 100 counting operands, correct adder, then drain
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(i), WIDTH'(2 * i), i[0], 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    edges = 0;
    while (busy && edges < 20) begin
      idle(1);
      edges++;
    end
    checkOutput("drain_edges", edges, 4);
    checkOutput("count_chk", chk_count, 100);
    checkOutput("count_err", err, 0);
    checkOutput("count_err_count", err_count, 0);

    // All-ones operands with carry-in: correct, then LSB corrupted
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, '1, '1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, '1, '1, 1'b1, 1'b1);
    idle(3);
    checkOutput("wrap_ok_err", err, 0);
    checkOutput("wrap_ok_chk", chk_count, 1);
    idle(3);
    checkOutput("wrap_bad_err", err, 1);
    checkOutput("wrap_fail_exp", fail_exp, allOnes);
    checkOutput("wrap_fail_got", fail_got, allOnesM1);
    checkOutput("wrap_err_count", err_count, 1);

    // Items 5,6,7 corrupted
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(3 * i), WIDTH'(i + 7), i[0], (i >= 5 && i <= 7));
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(8);
    checkOutput("multi_fail_exp", fail_exp, 129'h1C);
    checkOutput("multi_fail_got", fail_got, 129'h1D);
    checkOutput("multi_busy", busy, 0);
`ifdef ADDER_CHK_HALT_ON_ERROR_EN
    checkOutput("multi_err_count", err_count, 1);
    checkOutput("multi_chk_count", chk_count, 6);
`else
    checkOutput("multi_err_count", err_count, 3);
    checkOutput("multi_chk_count", chk_count, 10);
`endif

    // Reset with four entries in flight
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(i), WIDTH'(i), 1'b0, (i == 0));
    checkOutput("prerst_err", err, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_chk_count", chk_count, 0);
    checkOutput("rst_fail_exp", fail_exp, 0);
    checkOutput("rst_fail_got", fail_got, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(i), WIDTH'(i), 1'b0, 1'b1);
      checkOutput("postrst_chk", chk_count, 0);
      checkOutput("postrst_err_count", err_count, 0);
      checkOutput("postrst_busy", busy, 0);
    end
    idle(6);

    // start and stop together during RUN
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(i + 40), WIDTH'(i), 1'b1, (i == 0));
    checkOutput("prestart_err", err, 1);
    checkOutput("prestart_chk", chk_count, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, WIDTH'(77), WIDTH'(1), 1'b0, 1'b0);
    checkOutput("startstop_busy", busy, 1);
    checkOutput("startstop_chk", chk_count, 0);
    checkOutput("startstop_err", err, 0);
    checkOutput("startstop_err_count", err_count, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(i), WIDTH'(i + 9), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(8);
    checkOutput("startstop_final_chk", chk_count, 4);
    checkOutput("startstop_final_err", err, 0);

`ifndef ADDER_CHK_HALT_ON_ERROR_EN
    // Long error run to saturate err_count
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'(i), '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(8);
    checkOutput("sat_err_count", err_count, 16'hFFFF);
    checkOutput("sat_chk_count", chk_count, 65540);
    checkOutput("sat_err", err, 1);
`endif

    checking = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 Parameter WIDTH, default 128, operand width of the adder under check.
REQ-002 Parameter LATENCY, default 4, cycles from operand sample to matching adder result; legal range 1..16.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; clears all state and enters RUN.
REQ-006 stop  input  1  single-cycle pulse; stops sampling and drains in-flight checks.
REQ-007 in_valid  input  1  operands a/b/cin valid this cycle.
REQ-008 a, b  input  WIDTH each  operands presented to the adder.
REQ-009 cin  input  1  carry-in presented to the adder.
REQ-010 dut_result  input  WIDTH+1  adder output {cout,s}.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 err  output  1  sticky mismatch flag.
REQ-013 err_count  output  16  mismatch count, saturating.
REQ-014 chk_count  output  32  completed-comparison count, saturating.
REQ-015 fail_exp, fail_got  output  WIDTH+1 each  expected/actual values of first mismatch.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, FAIL.
REQ-017 IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE when delay line holds no valid entry; any state->RUN on start (start wins over simultaneous stop).
REQ-018 In RUN, an edge with in_valid=1 SHALL push expected = a + b + cin, computed at full WIDTH+1 bits with no truncation, plus a valid bit, into a LATENCY-deep delay line; otherwise a bubble is pushed.
REQ-019 In IDLE, DRAIN, FAIL only bubbles SHALL be pushed; in_valid is ignored.
REQ-020 An entry pushed at edge k SHALL be compared against dut_result sampled at edge k+LATENCY; counters, err, fail_* update at that edge.
REQ-021 Each valid comparison increments chk_count; a mismatch also increments err_count; both saturate at all-ones and never wrap.
REQ-022 First mismatch after start SHALL set err and capture fail_exp/fail_got; later mismatches SHALL NOT overwrite fail_*.
REQ-023 start SHALL clear delay line, counters, err, fail_* on the same edge; entries in flight at start are discarded uncompared.
REQ-024 Operand wrap-around: a=b=all-ones, cin=1 SHALL yield expected = all-ones of WIDTH+1 bits.
REQ-025 busy SHALL be combinational from state only.

Reset
REQ-026 rst asserted SHALL immediately force state IDLE, delay line invalid, err=0, err_count=0, chk_count=0, fail_exp=0, fail_got=0, busy=0.
REQ-027 rst mid-RUN SHALL discard all in-flight entries; first check after release requires a new start.

Configuration
REQ-028 Macro ADDER_CHK_HALT_ON_ERROR_EN defined: first mismatch moves FSM to FAIL; FAIL pushes bubbles, completes no further counting, and exits only via start or rst.
REQ-029 Macro undefined: FAIL is unreachable; checking continues in RUN/DRAIN after mismatches and err_count accumulates.

Verification
REQ-030 LATENCY=4, start, 100 valid operands from a counting source, dut_result = correct sum delayed 4 -> chk_count=100, err=0, err_count=0 after drain, busy falls after stop+4 edges.
REQ-031 a=b=all-ones, cin=1, correct DUT -> no error; corrupt dut_result LSB on that item -> err=1, fail_exp=all-ones, fail_got=all-ones minus 1.
REQ-032 Three corrupted results at items 5,6,7 without halt macro -> err_count=3, fail_* from item 5; with macro -> err_count=1, state FAIL, chk_count frozen at 6.
REQ-033 rst pulsed while 4 entries in flight -> all outputs zero immediately, no counter change for 4 following edges.
REQ-034 start and stop in same cycle during RUN -> stays RUN, counters cleared; err_count forced near 16'hFFFF via long error run -> saturates at 16'hFFFF.
